fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage and its surroundings (hazard unit,
// branch resolution, instruction memory and the decode stage).
interface fetch_stage_if;
    logic        freeze;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic [31:0] Inst_in;
    logic [31:0] Inst_addr;
    logic [31:0] IF_PC;
    logic [31:0] IF_Inst;
    logic        IF_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output freeze, Br_taken, Br_addr, Inst_in,
        input  Inst_addr, IF_PC, IF_Inst, IF_valid, stall_count, flush_count
    );

    modport slave (
        input  freeze, Br_taken, Br_addr, Inst_in,
        output Inst_addr, IF_PC, IF_Inst, IF_valid, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, and saturating
// stall/flush event counters. Priority per edge: reset > branch > freeze > advance.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);

    localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_WORD = RESET_PC & WORD_MASK;
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        flush;
    logic        hold;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    // A taken branch overrides freeze, so a frozen stage still gets redirected.
    always_comb begin
        flush     = bus.Br_taken;
        hold      = bus.freeze & ~bus.Br_taken;
        pc_plus4  = pc + 32'd4;
        br_target = bus.Br_addr & WORD_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC_WORD;
            if_pc    <= 32'h0000_0000;
            if_inst  <= 32'h0000_0000;
            if_valid <= 1'b0;
        end else if (flush) begin
            pc       <= br_target;
            if_pc    <= 32'h0000_0000;
            if_inst  <= 32'h0000_0000;
            if_valid <= 1'b0;
        end else if (!hold) begin
            pc       <= pc_plus4;
            if_pc    <= pc_plus4;
            if_inst  <= bus.Inst_in;
            if_valid <= 1'b1;
        end
    end

    // Counters stick at all-ones so long stalls never look like short ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (hold && stall_cnt != COUNT_MAX) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != COUNT_MAX) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign bus.Inst_addr   = pc;
    assign bus.IF_PC       = if_pc;
    assign bus.IF_Inst     = if_inst;
    assign bus.IF_valid    = if_valid;
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a rule-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   check_en = 1'b0;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word's contents encode its own address.
    assign bus.Inst_in = 32'h1000_0000 + bus.Inst_addr;

    // Reference model: expected architectural state after each edge.
    logic [31:0] m_pc, m_if_pc, m_if_inst;
    logic        m_if_valid;
    int          m_stall, m_flush;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 32'h0; m_if_pc = 32'h0; m_if_inst = 32'h0; m_if_valid = 1'b0;
            m_stall = 0; m_flush = 0;
        end else if (bus.Br_taken) begin
            m_pc = {bus.Br_addr[31:2], 2'b00};
            m_if_pc = 32'h0; m_if_inst = 32'h0; m_if_valid = 1'b0;
            m_flush = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
        end else if (bus.freeze) begin
            m_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        end else begin
            m_if_inst  = 32'h1000_0000 + m_pc;
            m_pc       = m_pc + 32'd4;
            m_if_pc    = m_pc;
            m_if_valid = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model Inst_addr", bus.Inst_addr, m_pc);
            check("model IF_PC", bus.IF_PC, m_if_pc);
            check("model IF_Inst", bus.IF_Inst, m_if_inst);
            check("model IF_valid", {31'b0, bus.IF_valid}, {31'b0, m_if_valid});
            check("model stall_count", {16'b0, bus.stall_count}, m_stall[31:0]);
            check("model flush_count", {16'b0, bus.flush_count}, m_flush[31:0]);
        end
    end

    task automatic apply_stimulus(input logic frz, input logic br, input logic [31:0] addr);
        bus.freeze   = frz;
        bus.Br_taken = br;
        bus.Br_addr  = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] addr, input logic [31:0] ifpc,
                                input logic [31:0] inst, input logic vld,
                                input logic [15:0] stalls, input logic [15:0] flushes);
        check({tag, " Inst_addr"}, bus.Inst_addr, addr);
        check({tag, " IF_PC"}, bus.IF_PC, ifpc);
        check({tag, " IF_Inst"}, bus.IF_Inst, inst);
        check({tag, " IF_valid"}, {31'b0, bus.IF_valid}, {31'b0, vld});
        check({tag, " stall_count"}, {16'b0, bus.stall_count}, {16'b0, stalls});
        check({tag, " flush_count"}, {16'b0, bus.flush_count}, {16'b0, flushes});
    endtask

    initial begin
        bus.freeze = 1'b0; bus.Br_taken = 1'b0; bus.Br_addr = 32'h0;
        #1 rst = 1'b1;
        #1 check_output("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        #10 rst = 1'b0;
        check_en = 1'b1;

        // Free run from reset.
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("run1", 32'h4, 32'h4, 32'h1000_0000, 1'b1, 16'd0, 16'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("run2", 32'h8, 32'h8, 32'h1000_0004, 1'b1, 16'd0, 16'd0);

        // Freeze two cycles at PC=8, then release with no bubble.
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("frz1", 32'h8, 32'h8, 32'h1000_0004, 1'b1, 16'd1, 16'd0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("frz2", 32'h8, 32'h8, 32'h1000_0004, 1'b1, 16'd2, 16'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rel", 32'hC, 32'hC, 32'h1000_0008, 1'b1, 16'd2, 16'd0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("run3", 32'h10, 32'h10, 32'h1000_000C, 1'b1, 16'd2, 16'd0);

        // Taken branch with misaligned target at PC=0x10.
        apply_stimulus(1'b0, 1'b1, 32'h0000_0103);
        check_output("br", 32'h100, 32'h0, 32'h0, 1'b0, 16'd2, 16'd1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("br_next", 32'h104, 32'h104, 32'h1000_0100, 1'b1, 16'd2, 16'd1);

        // Branch and freeze together: branch wins, no stall counted.
        apply_stimulus(1'b1, 1'b1, 32'h0000_0040);
        check_output("br_frz", 32'h40, 32'h0, 32'h0, 1'b0, 16'd2, 16'd2);

        // PC wraps from the top of the address space.
        apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        check_output("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 16'd2, 16'd3);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1, 16'd2, 16'd3);

        // Long freeze drives stall_count into saturation.
        bus.freeze = 1'b1;
        repeat (65532) @(posedge clk);
        #1 check_output("sat_m1", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1, 16'hFFFE, 16'd3);
        repeat (70000 - 65532) @(posedge clk);
        #1 check_output("sat", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1, 16'hFFFF, 16'd3);

        // Asynchronous reset between edges during a freeze.
        #2 rst = 1'b1;
        #1 check_output("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        apply_stimulus(1'b1, 1'b1, 32'h0000_0080);
        check_output("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
        bus.freeze = 1'b0; bus.Br_taken = 1'b0;
        #2 rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("post_rst", 32'h4, 32'h4, 32'h1000_0000, 1'b1, 16'd0, 16'd0);

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
